// File: rtl/counter_sched.sv
// counter_sched: round-robin scheduler that gives NREQ requesters timed intervals
// on a shared external 8-bit up-counter (load d via l, count via s_s, watch c).
module counter_sched #(
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] len,
  input  logic [7:0]        c,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic              l,
  output logic              s_s,
  output logic [7:0]        d,
  output logic [1:0]        fsm_state
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [IW-1:0] last_g;
  logic [IW-1:0] g_idx;
  logic [IW-1:0] pick;
  logic [IW-1:0] cand;
  logic          pick_ok;
  logic [7:0]    pick_len;
  logic          grant_en;
  logic          release_en;
  int            idx;

  // Handshake: req[i] is a level held until done[i] pulses (interval complete) or
  // until the requester drops it to abandon; gnt[i] marks ownership in between.

  // Round-robin search begins one past the last served requester.
  always_comb begin : arbiter
    pick    = last_g;
    pick_ok = 1'b0;
    cand    = '0;
    idx     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx  = (int'(last_g) + k) % NREQ;
      cand = IW'(idx);
      if (!pick_ok && req[cand]) begin
        pick_ok = 1'b1;
        pick    = cand;
      end
    end
  end

  assign pick_len = len[{pick, 3'b000} +: 8];

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin : fsm_next
    state_next = state;
    grant_en   = 1'b0;
    release_en = 1'b0;
    case (state)
      IDLE: begin
        if (pick_ok) begin
          grant_en   = 1'b1;
          state_next = (pick_len == 8'h00) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (!req[g_idx]) begin
          release_en = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = RUN;
        end
      end
      RUN: begin
        // Leaving on c==FF lets the counter's own wrap to 00 be the final step.
        if (!req[g_idx]) begin
          release_en = 1'b1;
          state_next = IDLE;
        end else if (c == 8'hFF) begin
          state_next = DONE;
        end
      end
      DONE: begin
        release_en = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      gnt    <= '0;
      g_idx  <= '0;
      last_g <= IW'(NREQ - 1);
      d      <= 8'h00;
    end else if (grant_en) begin
      gnt   <= NREQ'(1) << pick;
      g_idx <= pick;
      if (pick_len != 8'h00) begin
        d <= 8'h00 - pick_len;
      end
    end else if (release_en) begin
      gnt    <= '0;
      last_g <= g_idx;
    end
  end

  assign l         = (state == LOAD);
  assign s_s       = (state == RUN);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE) ? gnt : '0;
  assign fsm_state = state;

endmodule

// File: tb/tb_counter_sched.sv
// tb_counter_sched: directed vector table plus hand-written multi-cycle sequences
// for counter_sched, with a behavioural model of the shared 8-bit counter.
module tb_counter_sched;

  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              clr;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] len;
  logic [7:0]        c;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic              busy;
  logic              l;
  logic              s_s;
  logic [7:0]        d;
  logic [1:0]        fsm_state;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] len;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        l;
    logic        s_s;
    logic        busy;
    logic [7:0]  d;
    logic [7:0]  c;
  } vec_t;

  vec_t       vecs[$];
  logic [1:0] exp_q[$];
  logic [1:0] got_q[$];

  // clock / reset
  always #5 clk = ~clk;

  // external counter the scheduler drives
  always @(posedge clk or negedge clr) begin
    if (!clr)     c <= 8'h00;
    else if (l)   c <= d;
    else if (s_s) c <= c + 8'h01;
  end

  counter_sched #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .clr       (clr),
    .req       (req),
    .len       (len),
    .c         (c),
    .gnt       (gnt),
    .done      (done),
    .busy      (busy),
    .l         (l),
    .s_s       (s_s),
    .d         (d),
    .fsm_state (fsm_state)
  );

  // driver / checker tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [3:0] r, input logic [31:0] ln, input logic [3:0] g,
                         input logic [3:0] dn, input logic el, input logic ss,
                         input logic bz, input logic [7:0] dd, input logic [7:0] cc);
    vec_t v;
    v.req = r; v.len = ln; v.gnt = g; v.done = dn;
    v.l = el; v.s_s = ss; v.busy = bz; v.d = dd; v.c = cc;
    vecs.push_back(v);
  endtask

  function automatic logic [1:0] idx_of(input logic [3:0] oh);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
    return r;
  endfunction

  initial begin
    int         dn_cnt;
    int         runs;
    logic       got_done;
    logic       seen_ff;
    logic [3:0] prev;

    //        req      len           gnt      done     l     s_s   busy  d      c
    add_vec(4'b0000, 32'h00000000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    add_vec(4'b0001, 32'h00000005, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b1, 8'hFB, 8'h00);
    add_vec(4'b0001, 32'h09090909, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b1, 8'hFB, 8'hFB);
    add_vec(4'b0011, 32'h09090909, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b1, 8'hFB, 8'hFC);
    add_vec(4'b0011, 32'h09090909, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b1, 8'hFB, 8'hFD);
    add_vec(4'b0011, 32'h09090909, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b1, 8'hFB, 8'hFE);
    add_vec(4'b0011, 32'h09090909, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b1, 8'hFB, 8'hFF);
    add_vec(4'b0001, 32'h09090909, 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b1, 8'hFB, 8'h00);
    add_vec(4'b0000, 32'h09090909, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 8'hFB, 8'h00);
    add_vec(4'b0100, 32'h00000000, 4'b0100, 4'b0100, 1'b0, 1'b0, 1'b1, 8'hFB, 8'h00);
    add_vec(4'b0100, 32'h00000000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 8'hFB, 8'h00);
    add_vec(4'b0000, 32'h00000000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 8'hFB, 8'h00);
    add_vec(4'b1000, 32'h01000000, 4'b1000, 4'b0000, 1'b1, 1'b0, 1'b1, 8'hFF, 8'h00);
    add_vec(4'b1000, 32'h01000000, 4'b1000, 4'b0000, 1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF);
    add_vec(4'b1000, 32'h01000000, 4'b1000, 4'b1000, 1'b0, 1'b0, 1'b1, 8'hFF, 8'h00);
    add_vec(4'b0000, 32'h01000000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h00);

    // reset state
    clr = 1'b1; req = '0; len = '0;
    #1 clr = 1'b0;
    #1;
    check("reset gnt", gnt, 4'b0000);
    check("reset done", done, 4'b0000);
    check("reset l/s_s/busy", {l, s_s, busy}, 3'b000);
    check("reset d", d, 8'h00);
    check("reset state", fsm_state, 2'd0);
    repeat (2) @(posedge clk);
    #1 clr = 1'b1;

    // table: single len=5, zero length, len=1, ignored len/req changes
    foreach (vecs[i]) begin
      req = vecs[i].req;
      len = vecs[i].len;
      step();
      check($sformatf("v%0d gnt", i), gnt, vecs[i].gnt);
      check($sformatf("v%0d done", i), done, vecs[i].done);
      check($sformatf("v%0d l/s_s/busy", i), {l, s_s, busy}, {vecs[i].l, vecs[i].s_s, vecs[i].busy});
      check($sformatf("v%0d d", i), d, vecs[i].d);
      check($sformatf("v%0d c", i), c, vecs[i].c);
    end

    // round-robin with all requests held, len 3 each
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    req = 4'b1111; len = 32'h03030303; prev = '0; dn_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      check("rr onehot", 32'($countones(gnt) <= 1), 32'd1);
      if (prev == 4'b0000 && gnt != 4'b0000) got_q.push_back(idx_of(gnt));
      if (done != 4'b0000) begin
        if (dn_cnt < exp_q.size()) check($sformatf("rr done %0d", dn_cnt), done, 4'b0001 << exp_q[dn_cnt]);
        dn_cnt++;
      end
      prev = gnt;
    end
    req = 4'b0000;
    check("rr grant count", got_q.size(), exp_q.size());
    check("rr done count", dn_cnt, exp_q.size());
    foreach (exp_q[i]) if (i < got_q.size()) check($sformatf("rr grant %0d", i), got_q[i], exp_q[i]);
    step();
    check("rr idle busy", busy, 1'b0);

    // maximum length 255
    req = 4'b0001; len = 32'h000000FF;
    step();
    check("wrap gnt", gnt, 4'b0001);
    check("wrap l", l, 1'b1);
    check("wrap d", d, 8'h01);
    runs = 0; got_done = 1'b0; seen_ff = 1'b0;
    for (int i = 0; i < 300 && !got_done; i++) begin
      step();
      if (s_s) runs++;
      if (s_s && c == 8'hFF) seen_ff = 1'b1;
      if (done != 4'b0000) begin
        got_done = 1'b1;
        check("wrap done", done, 4'b0001);
        check("wrap c end", c, 8'h00);
      end
    end
    check("wrap done seen", got_done, 1'b1);
    check("wrap run cycles", runs, 255);
    check("wrap c reached FF", seen_ff, 1'b1);
    req = 4'b0000;
    step();

    // abort requester 1 three cycles into RUN, requester 2 pending
    req = 4'b0110; len = 32'h00020A00;
    step();
    check("abort gnt", gnt, 4'b0010);
    check("abort d", d, 8'hF6);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("abort run %0d", i), s_s, 1'b1);
    end
    req = 4'b0100;
    step();
    check("abort s_s", s_s, 1'b0);
    check("abort gnt clear", gnt, 4'b0000);
    check("abort no done", done, 4'b0000);
    check("abort busy", busy, 1'b0);
    step();
    check("abort next gnt", gnt, 4'b0100);
    check("abort next l", l, 1'b1);
    check("abort next d", d, 8'hFE);
    got_done = 1'b0;
    for (int i = 0; i < 10 && !got_done; i++) begin
      step();
      if (done != 4'b0000) begin
        got_done = 1'b1;
        check("abort req2 done", done, 4'b0100);
      end
    end
    check("abort req2 done seen", got_done, 1'b1);
    req = 4'b0000;
    step();

    // reset during RUN, then re-arbitrate from requester 0
    req = 4'b1001; len = 32'h14000014;
    step();
    check("rst pre gnt", gnt, 4'b1000);
    step();
    step();
    check("rst pre s_s", s_s, 1'b1);
    #2 clr = 1'b0;
    #1;
    check("rst async s_s", s_s, 1'b0);
    check("rst async gnt", gnt, 4'b0000);
    check("rst async busy", busy, 1'b0);
    check("rst async done", done, 4'b0000);
    check("rst async d", d, 8'h00);
    step();
    check("rst held busy", busy, 1'b0);
    clr = 1'b1;
    step();
    check("rst rearb gnt", gnt, 4'b0001);
    check("rst rearb l", l, 1'b1);
    check("rst rearb d", d, 8'hEC);
    req = 4'b0000;
    step();
    check("rst drop busy", busy, 1'b0);
    check("rst drop done", done, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
